// File: rtl/edge_event_pkg.sv
// Shared types, width helper and reset constants for the edge event arbiter.
package edge_event_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   // Index width for n channels, never narrower than one bit
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_VALID = 1'b0;

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... with wrap.
module edge_event_rr_pick
   import edge_event_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic              any,
   output logic [IDX_W-1:0]  idx
);

   // Scan from the farthest offset down so the nearest one to ptr is assigned last
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_CH]) begin
            any = 1'b1;
            idx = IDX_W'((int'(ptr) + k) % NUM_CH);
         end
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// Trailing-edge event latch with round-robin valid/ready delivery.
// Optional sticky overrun flags: define EDGE_EVENT_ARB_OVERRUN_EN.
module edge_event_arbiter
   import edge_event_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = idx_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              ares,
   input  logic              sres,
   input  logic              ld_en,
   input  logic [NUM_CH-1:0] Level_In,
   output logic              Ev_Valid,
   input  logic              Ev_Ready,
   output logic [IDX_W-1:0]  Ev_Chan,
   output logic [NUM_CH-1:0] Ev_Pend
`ifdef EDGE_EVENT_ARB_OVERRUN_EN
   ,
   output logic [NUM_CH-1:0] Overrun
`endif
);

   state_t              state;
   logic [NUM_CH-1:0]   level_delay;
   logic [IDX_W-1:0]    rr_ptr;
   logic [NUM_CH-1:0]   edge_vec;
   logic [NUM_CH-1:0]   grant_vec;
   logic [NUM_CH-1:0]   pend_next;
   logic [IDX_W-1:0]    ptr_after;
   logic                handshake;
   logic [NUM_CH-1:0]   pick_req;
   logic [IDX_W-1:0]    pick_ptr;
   logic                pick_any;
   logic [IDX_W-1:0]    pick_idx;

   assign edge_vec  = {NUM_CH{ld_en}} & ~Level_In & level_delay;
   assign handshake = Ev_Valid & Ev_Ready;
   assign ptr_after = IDX_W'((int'(Ev_Chan) + 1) % NUM_CH);

   always_comb begin
      grant_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         grant_vec[i] = handshake & (Ev_Chan == IDX_W'(i));
      end
   end

   // A same-cycle edge re-arms a channel even while it is being granted
   assign pend_next = (Ev_Pend & ~grant_vec) | edge_vec;

   // Idle offers from the registered pending vector, giving edge-to-valid latency of two
   assign pick_req = (state == ST_OFFER) ? pend_next : Ev_Pend;
   assign pick_ptr = (state == ST_OFFER && Ev_Ready) ? ptr_after : rr_ptr;

   edge_event_rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req (pick_req),
      .ptr (pick_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or posedge ares) begin
      if (ares) begin
         state       <= RST_STATE;
         Ev_Valid    <= RST_VALID;
         Ev_Chan     <= '0;
         Ev_Pend     <= '0;
         level_delay <= '0;
         rr_ptr      <= '0;
      end else if (sres) begin
         state       <= RST_STATE;
         Ev_Valid    <= RST_VALID;
         Ev_Chan     <= '0;
         Ev_Pend     <= '0;
         level_delay <= '0;
         rr_ptr      <= '0;
      end else begin
         if (ld_en) begin
            level_delay <= Level_In;
         end
         Ev_Pend <= pend_next;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  state    <= ST_OFFER;
                  Ev_Valid <= 1'b1;
                  Ev_Chan  <= pick_idx;
               end
            end
            ST_OFFER: begin
               if (Ev_Ready) begin
                  rr_ptr <= ptr_after;
                  if (pick_any) begin
                     Ev_Chan <= pick_idx;
                  end else begin
                     state    <= ST_IDLE;
                     Ev_Valid <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               Ev_Valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef EDGE_EVENT_ARB_OVERRUN_EN
   // Flag a second edge that lands on a channel still waiting to be served
   always_ff @(posedge clk or posedge ares) begin
      if (ares) begin
         Overrun <= '0;
      end else if (sres) begin
         Overrun <= '0;
      end else begin
         Overrun <= Overrun | (edge_vec & Ev_Pend & ~grant_vec);
      end
   end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter (NUM_CH=4); handles EDGE_EVENT_ARB_OVERRUN_EN on or off.
module tb_edge_event_arbiter;

   localparam int NUM_CH = 4;
   localparam int IDX_W  = 2;

   logic              clk = 1'b0;
   logic              ares;
   logic              sres;
   logic              ld_en;
   logic [NUM_CH-1:0] Level_In;
   logic              Ev_Valid;
   logic              Ev_Ready;
   logic [IDX_W-1:0]  Ev_Chan;
   logic [NUM_CH-1:0] Ev_Pend;
`ifdef EDGE_EVENT_ARB_OVERRUN_EN
   logic [NUM_CH-1:0] Overrun;
`endif

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   edge_event_arbiter #(
      .NUM_CH (NUM_CH)
   ) dut (
      .clk      (clk),
      .ares     (ares),
      .sres     (sres),
      .ld_en    (ld_en),
      .Level_In (Level_In),
      .Ev_Valid (Ev_Valid),
      .Ev_Ready (Ev_Ready),
      .Ev_Chan  (Ev_Chan),
      .Ev_Pend  (Ev_Pend)
`ifdef EDGE_EVENT_ARB_OVERRUN_EN
      ,
      .Overrun  (Overrun)
`endif
   );

   task automatic stepClock(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [NUM_CH-1:0] lvl, input logic ld, input logic rdy);
      Level_In = lvl;
      ld_en    = ld;
      Ev_Ready = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted offer must match the next expected channel
   always @(negedge clk) begin
      if (!ares && !sres && Ev_Valid && Ev_Ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL ev_chan_unexpected: got %0d expected none", Ev_Chan);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(Ev_Chan) != e) begin
               errors++;
               $display("[TB] FAIL ev_chan_order: got %0d expected %0d", Ev_Chan, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ares = 1'b1;
      sres = 1'b0;
      applyStimulus(4'hF, 1'b1, 1'b0);

      // Reset state and first detection
      stepClock(2);
      checkOutput("rst_valid", 32'(Ev_Valid), 32'h0);
      checkOutput("rst_chan", 32'(Ev_Chan), 32'h0);
      checkOutput("rst_pend", 32'(Ev_Pend), 32'h0);
`ifdef EDGE_EVENT_ARB_OVERRUN_EN
      checkOutput("rst_overrun", 32'(Overrun), 32'h0);
`endif
      ares = 1'b0;
      stepClock();
      applyStimulus(4'h0, 1'b1, 1'b0);
      stepClock();
      checkOutput("t1_pend_all", 32'(Ev_Pend), 32'hF);
      checkOutput("t1_valid_not_yet", 32'(Ev_Valid), 32'h0);
      stepClock();
      checkOutput("t1_valid", 32'(Ev_Valid), 32'h1);
      checkOutput("t1_chan0_first", 32'(Ev_Chan), 32'h0);
      sres = 1'b1;
      stepClock();
      sres = 1'b0;
      checkOutput("sres_valid", 32'(Ev_Valid), 32'h0);
      checkOutput("sres_pend", 32'(Ev_Pend), 32'h0);
      checkOutput("sres_chan", 32'(Ev_Chan), 32'h0);

      // Latency and back-to-back round robin
      applyStimulus(4'hF, 1'b1, 1'b1);
      stepClock();
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(3);
      applyStimulus(4'h1, 1'b1, 1'b1);
      stepClock();
      checkOutput("t2_pend", 32'(Ev_Pend), 32'hE);
      checkOutput("t2_valid_n1", 32'(Ev_Valid), 32'h0);
      stepClock();
      checkOutput("t2_valid_n2", 32'(Ev_Valid), 32'h1);
      checkOutput("t2_chan_first", 32'(Ev_Chan), 32'h1);
      stepClock(3);
      checkOutput("t2_idle_after", 32'(Ev_Valid), 32'h0);
      checkOutput("t2_pend_clear", 32'(Ev_Pend), 32'h0);

      // Stall with ch2 offered and ch0 pending, then wrap to ch0
      applyStimulus(4'hF, 1'b1, 1'b0);
      stepClock();
      applyStimulus(4'hB, 1'b1, 1'b0);
      stepClock(2);
      applyStimulus(4'hA, 1'b1, 1'b0);
      stepClock();
      checkOutput("t3_pend", 32'(Ev_Pend), 32'h5);
      for (int i = 0; i < 5; i++) begin
         stepClock();
         checkOutput("t3_stall_chan", 32'(Ev_Chan), 32'h2);
         checkOutput("t3_stall_valid", 32'(Ev_Valid), 32'h1);
      end
      exp_q.push_back(2);
      exp_q.push_back(0);
      applyStimulus(4'hA, 1'b1, 1'b1);
      stepClock();
      checkOutput("t3_wrap_chan", 32'(Ev_Chan), 32'h0);
      stepClock();
      checkOutput("t3_idle", 32'(Ev_Valid), 32'h0);

      // ld_en low hides the ch0 pulse; re-enabling with ch0 low stays quiet
      applyStimulus(4'hB, 1'b0, 1'b1);
      stepClock(2);
      applyStimulus(4'hA, 1'b0, 1'b1);
      stepClock(2);
      checkOutput("t4_no_event", 32'(Ev_Pend), 32'h0);
      applyStimulus(4'hA, 1'b1, 1'b1);
      stepClock(2);
      checkOutput("t4_reenable_pend", 32'(Ev_Pend), 32'h0);
      checkOutput("t4_reenable_valid", 32'(Ev_Valid), 32'h0);

      // Grant and new edge on ch1 in the same cycle
      applyStimulus(4'h0, 1'b1, 1'b0);
      stepClock(2);
      checkOutput("t5_offer_ch1", 32'(Ev_Chan), 32'h1);
      applyStimulus(4'h2, 1'b1, 1'b0);
      stepClock();
      exp_q.push_back(1);
      exp_q.push_back(3);
      exp_q.push_back(1);
      applyStimulus(4'h0, 1'b1, 1'b1);
      stepClock();
      checkOutput("t5_pend_kept", 32'(Ev_Pend), 32'hA);
      checkOutput("t5_next_ch3", 32'(Ev_Chan), 32'h3);
      stepClock(2);
      checkOutput("t5_idle", 32'(Ev_Valid), 32'h0);

      // Second ch3 edge while still pending and stalled
      applyStimulus(4'h8, 1'b1, 1'b0);
      stepClock();
      applyStimulus(4'h0, 1'b1, 1'b0);
      stepClock(2);
      checkOutput("t6_offer_ch3", 32'(Ev_Chan), 32'h3);
      applyStimulus(4'h8, 1'b1, 1'b0);
      stepClock();
      applyStimulus(4'h0, 1'b1, 1'b0);
      stepClock();
      checkOutput("t6_pend_merged", 32'(Ev_Pend), 32'h8);
`ifdef EDGE_EVENT_ARB_OVERRUN_EN
      checkOutput("t6_overrun_set", 32'(Overrun), 32'h8);
`endif
      exp_q.push_back(3);
      applyStimulus(4'h0, 1'b1, 1'b1);
      stepClock(2);
      checkOutput("t6_idle", 32'(Ev_Valid), 32'h0);
      checkOutput("t6_pend_clear", 32'(Ev_Pend), 32'h0);
`ifdef EDGE_EVENT_ARB_OVERRUN_EN
      checkOutput("t6_overrun_sticky", 32'(Overrun), 32'h8);
      sres = 1'b1;
      stepClock();
      sres = 1'b0;
      checkOutput("t6_overrun_sres", 32'(Overrun), 32'h0);
`endif

      // Drain: every queued expectation must have been consumed
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         stepClock();
      end
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
